// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the cpu_seq instruction sequencer.
package cpu_seq_pkg;

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned OP_LSB  = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam logic [OP_W-1:0] OP_NOP = 2'b00;
  localparam logic [OP_W-1:0] OP_LD  = 2'b01;
  localparam logic [OP_W-1:0] OP_JMP = 2'b10;
  localparam logic [OP_W-1:0] OP_HLT = 2'b11;

  // Opcode field of an instruction word.
  function automatic logic [OP_W-1:0] get_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_LSB +: OP_W];
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser plus registered rising-edge detector for the step button.
// Edges are only recognised once the synchronised input has been seen low after reset.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q,  prev_d;
  logic [1:0] vld_q,   vld_d;
  logic       armed_q, armed_d;
  logic       pulse_q, pulse_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    vld_d   = {vld_q[0], 1'b1};
    // A button held through reset release must be let go before it can step.
    armed_d = armed_q | (vld_q[1] & ~sync2_q);
    pulse_d = armed_q & sync2_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      vld_q   <= vld_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/cpu_seq.sv
// Tiny fetch/execute sequencer: one instruction per start condition (TICK with RUN).
// Define CPU_SEQ_STEP_EN to add the STEP button port and single-step logic.
module cpu_seq
  import cpu_seq_pkg::*;
#(
  parameter int unsigned ADR_W  = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TICK,
  input  logic              RUN,
`ifdef CPU_SEQ_STEP_EN
  input  logic              STEP,
`endif
  output logic [ADR_W-1:0]  ROM_ADR,
  output logic              ROM_EN,
  input  logic [DATA_W-1:0] ROM_DATA,
  output logic              LD0,
  output logic              HALTED
);

  state_e              state_q, state_d;
  logic [ADR_W-1:0]    pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic                ld0_q, ld0_d;
  logic                rom_en_q, rom_en_d;
  logic                halted_q, halted_d;
  logic                start_c;

`ifdef CPU_SEQ_STEP_EN
  logic step_pulse;

  edge_sync u_step_sync (
    .clk   (CLK),
    .rst_n (RST),
    .din   (STEP),
    .pulse (step_pulse)
  );

  assign start_c = (TICK & RUN) | (step_pulse & ~RUN);
`else
  assign start_c = TICK & RUN;
`endif

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ld0_d    = ld0_q;
    rom_en_d = 1'b0;
    halted_d = 1'b0;

    unique case (state_q)
      ST_IDLE:  if (start_c) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        ir_d    = ROM_DATA;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        case (get_op(ir_q))
          OP_NOP: pc_d = pc_q + ADR_W'(1);
          OP_LD: begin
            ld0_d = ir_q[0];
            pc_d  = pc_q + ADR_W'(1);
          end
          OP_JMP:  pc_d = ir_q[ADR_W-1:0];
          default: state_d = ST_HALT;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    rom_en_d = (state_d == ST_FETCH);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      ld0_q    <= 1'b0;
      rom_en_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ld0_q    <= ld0_d;
      rom_en_q <= rom_en_d;
      halted_q <= halted_d;
    end
  end

  assign ROM_ADR = pc_q;
  assign ROM_EN  = rom_en_q;
  assign LD0     = ld0_q;
  assign HALTED  = halted_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Directed bench for cpu_seq with a behavioural one-cycle-latency ROM.
module tb_cpu_seq;

  localparam int unsigned ADR_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick;
  logic             run;
  logic [ADR_W-1:0] rom_adr;
  logic             rom_en;
  logic [7:0]       rom_data;
  logic             ld0;
  logic             halted;
`ifdef CPU_SEQ_STEP_EN
  logic             step;
`endif

  logic [7:0] rom [64];
  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= rom[rom_adr];

  cpu_seq #(.ADR_W(ADR_W), .DATA_W(8)) dut (
    .CLK      (clk),
    .RST      (rst),
    .TICK     (tick),
    .RUN      (run),
`ifdef CPU_SEQ_STEP_EN
    .STEP     (step),
`endif
    .ROM_ADR  (rom_adr),
    .ROM_EN   (rom_en),
    .ROM_DATA (rom_data),
    .LD0      (ld0),
    .HALTED   (halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hold reset low for two cycles with TICK=1, check cleared outputs, release.
  task automatic do_reset(input string tag);
    rst  = 1'b0;
    tick = 1'b1;
    run  = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, "_pc"},     32'(rom_adr), 32'd0);
    chk({tag, "_ld0"},    32'(ld0),     32'd0);
    chk({tag, "_rom_en"}, 32'(rom_en),  32'd0);
    chk({tag, "_halted"}, 32'(halted),  32'd0);
    rst  = 1'b1;
    tick = 1'b0;
    @(negedge clk);
  endtask

  // One TICK pulse; the fetch must appear next cycle at exp_adr, then wait out the instruction.
  task automatic run_instr(input string tag, input logic [ADR_W-1:0] exp_adr);
    tick = 1'b1;
    @(negedge clk);
    chk({tag, "_fetch_en"},  32'(rom_en),  32'd1);
    chk({tag, "_fetch_adr"}, 32'(rom_adr), 32'(exp_adr));
    tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int en_cnt;
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int en_cnt;
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    rst  = 1'b0;
    tick = 1'b0;
    run  = 1'b0;
`ifdef CPU_SEQ_STEP_EN
    step = 1'b0;
`endif

    do_reset("rst0");

    // Program: LD 1, LD 0, NOP, HLT
    rom[0] = 8'h41; rom[1] = 8'h40; rom[2] = 8'h00; rom[3] = 8'hC0;
    run_instr("p0", 6'd0);
    chk("p0_ld0", 32'(ld0), 32'd1);
    chk("p0_pc",  32'(rom_adr), 32'd1);
    run_instr("p1", 6'd1);
    chk("p1_ld0", 32'(ld0), 32'd0);
    chk("p1_pc",  32'(rom_adr), 32'd2);
    run_instr("p2", 6'd2);
    chk("p2_ld0", 32'(ld0), 32'd0);
    chk("p2_pc",  32'(rom_adr), 32'd3);
    run_instr("p3", 6'd3);
    chk("p3_halted", 32'(halted), 32'd1);
    chk("p3_pc",     32'(rom_adr), 32'd3);
    tick = 1'b1;
    @(negedge clk);
    chk("halt_no_fetch", 32'(rom_en), 32'd0);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("halt_stays", 32'(halted),  32'd1);
    chk("halt_pc",    32'(rom_adr), 32'd3);

    // Jump to 63, wrap via NOP to 0, jump to 5, self-loop at 5.
    do_reset("rst_halt");
    rom[0]  = 8'hBF;
    rom[63] = 8'h00;
    rom[5]  = 8'h85;
    run_instr("j63", 6'd0);
    chk("j63_pc", 32'(rom_adr), 32'd63);
    rom[0] = 8'h85;
    run_instr("wrap", 6'd63);
    chk("wrap_pc", 32'(rom_adr), 32'd0);
    run_instr("j5", 6'd0);
    chk("j5_pc", 32'(rom_adr), 32'd5);
    run_instr("self", 6'd5);
    chk("self_pc", 32'(rom_adr), 32'd5);
    run_instr("self2", 6'd5);

    // TICK on two consecutive cycles yields one fetch.
    do_reset("rst_busy");
    rom[0] = 8'h00;
    rom[1] = 8'h41;
    en_cnt = 0;
    tick = 1'b1;
    @(negedge clk);
    en_cnt += int'(rom_en);
    @(negedge clk);
    en_cnt += int'(rom_en);
    tick = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en_cnt += int'(rom_en);
    end
    chk("busy_en_cnt", 32'(en_cnt),  32'd1);
    chk("busy_pc",     32'(rom_adr), 32'd1);

    // RUN dropping mid-instruction still completes it, then holds in IDLE.
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    run  = 1'b0;
    repeat (3) @(negedge clk);
    chk("runfall_ld0", 32'(ld0),     32'd1);
    chk("runfall_pc",  32'(rom_adr), 32'd2);
    tick = 1'b1;
    @(negedge clk);
    chk("runoff_no_fetch", 32'(rom_en), 32'd0);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("runoff_pc", 32'(rom_adr), 32'd2);

    // Reset during WAIT with an LD 1 on the ROM bus.
    do_reset("rst_mid");
    rom[0] = 8'h41;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_pc",     32'(rom_adr), 32'd0);
    chk("midrst_rom_en", 32'(rom_en),  32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_ld0",  32'(ld0),     32'd0);
    chk("midrst_pc2",  32'(rom_adr), 32'd0);

`ifdef CPU_SEQ_STEP_EN
    // Held STEP with RUN=0 executes exactly one instruction.
    do_reset("rst_step");
    run = 1'b0;
    repeat (4) @(negedge clk);
    rom[0] = 8'h41;
    rom[1] = 8'h40;
    en_cnt = 0;
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en_cnt += int'(rom_en);
    end
    step = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en_cnt += int'(rom_en);
    end
    chk("step_en_cnt", 32'(en_cnt),  32'd1);
    chk("step_pc",     32'(rom_adr), 32'd1);
    chk("step_ld0",    32'(ld0),     32'd1);

    // STEP with RUN=1 is ignored.
    run  = 1'b1;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (10) @(negedge clk);
    chk("step_run_pc", 32'(rom_adr), 32'd1);

    // STEP held through reset release produces no step.
    step = 1'b1;
    rst  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    repeat (10) @(negedge clk);
    chk("step_held_pc", 32'(rom_adr), 32'd0);
    step = 1'b0;
    repeat (4) @(negedge clk);
    step = 1'b1;
    repeat (10) @(negedge clk);
    step = 1'b0;
    chk("step_rearm_pc", 32'(rom_adr), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
